// File: rtl/ycr1_wb_burst_pkg.sv
// Shared types and helpers for the Wishbone burst initiator.
package ycr1_wb_burst_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DONE,
    ERR_DONE
  } type_wbm_state_e;

  localparam int YCR1_WBM_FIFO_DEPTH = 2;

  // Bursts always start on a word boundary; the byte offset is dropped.
  function automatic logic [31:0] ycr1_wbm_align_addr(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ycr1_wbm_fifo2.sv
// Two-entry FIFO with flush; a push into a full FIFO is accepted when a pop happens in the same cycle.
module ycr1_wbm_fifo2
  import ycr1_wb_burst_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic [1:0]   cnt
);

  logic [W-1:0] mem [YCR1_WBM_FIFO_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && (!full || do_pop);

  assign head  = mem[rd_ptr];
  assign full  = (count == 2'(YCR1_WBM_FIFO_DEPTH));
  assign empty = (count == 2'd0);
  assign cnt   = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ycr1_wb_burst_master.sv
// Wishbone burst initiator: one command becomes one burst, with stream-side
// buffering, an ack watchdog and error termination.
module ycr1_wb_burst_master
  import ycr1_wb_burst_pkg::*;
#(
  parameter int BL_W  = 10,
  parameter int TMO_W = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [31:0]     cmd_addr,
  input  logic            cmd_we,
  input  logic [BL_W-1:0] cmd_len,
  input  logic [3:0]      cmd_sel,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [31:0]     wr_data,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [31:0]     rd_data,
  output logic            rd_last,
  output logic            wbd_stb_o,
  output logic [31:0]     wbd_adr_o,
  output logic            wbd_we_o,
  output logic [31:0]     wbd_dat_o,
  output logic [3:0]      wbd_sel_o,
  output logic [BL_W-1:0] wbd_bl_o,
  output logic            wbd_bry_o,
  input  logic [31:0]     wbd_dat_i,
  input  logic            wbd_ack_i,
  input  logic            wbd_lack_i,
  input  logic            wbd_err_i,
  output logic            done,
  output logic            err
);

  localparam logic [TMO_W-1:0] TMO_MAX  = {TMO_W{1'b1}};
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_MAX - TMO_W'(1);

  type_wbm_state_e state;
  type_wbm_state_e state_next;

  logic [BL_W-1:0]  beat_cnt;
  logic [TMO_W-1:0] wdog;
  logic             err_q;
  logic             cmd_accept;
  logic             beat;
  logic             burst_end;
  logic             burst_fail;

  logic             wr_flush;
  logic             wr_push;
  logic             wr_pop;
  logic             wr_full;
  logic             wr_empty;
  logic [1:0]       wr_cnt;

  logic             rd_push;
  logic             rd_pop;
  logic             rd_full;
  logic             rd_empty;
  logic [1:0]       rd_cnt;
  logic [32:0]      rd_head;
  logic             rd_overflow;

  assign cmd_ready  = (state == IDLE);
  assign cmd_accept = cmd_ready && cmd_valid;
  assign wbd_stb_o  = (state == BURST);
  assign beat       = wbd_stb_o && wbd_ack_i;

  assign done = (state == DONE) || (state == ERR_DONE);
  assign err  = (state == ERR_DONE) || ((state == DONE) && err_q);

  // An aborted write burst discards whatever the producer had queued up.
  assign wr_flush = (state == DONE) && err_q;
  assign wr_ready = !wr_full && !wr_flush;
  assign wr_push  = wr_valid && wr_ready;
  assign wr_pop   = beat && wbd_we_o && !wr_empty;

  assign rd_overflow = beat && !wbd_we_o && rd_full;
  assign rd_push     = beat && !wbd_we_o && !rd_full;
  assign rd_pop      = rd_valid && rd_ready;
  assign rd_valid    = !rd_empty;
  assign rd_last     = rd_head[32];
  assign rd_data     = rd_head[31:0];

  // For reads, only signal ready when an extra in-flight beat still fits.
  always_comb begin
    wbd_bry_o = 1'b0;
    if (wbd_stb_o) begin
      if (wbd_we_o) begin
        wbd_bry_o = (wr_cnt != 2'd0);
      end else begin
        wbd_bry_o = (rd_cnt == 2'd0) || ((rd_cnt == 2'd1) && rd_ready);
      end
    end
  end

  always_comb begin
    burst_end  = 1'b0;
    burst_fail = 1'b0;
    if (state == BURST) begin
      if (wbd_err_i) begin
        burst_end  = 1'b1;
        burst_fail = 1'b1;
      end else if (!wbd_ack_i && (wdog == TMO_LAST)) begin
        burst_end  = 1'b1;
        burst_fail = 1'b1;
      end else if (rd_overflow) begin
        burst_end  = 1'b1;
        burst_fail = 1'b1;
      end else if (beat && (beat_cnt == BL_W'(1))) begin
        burst_end = 1'b1;
      end else if (wbd_lack_i && (beat_cnt != BL_W'(1))) begin
        burst_end  = 1'b1;
        burst_fail = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_next = (cmd_len == '0) ? ERR_DONE : BURST;
        end
      end
      BURST: begin
        if (burst_end) begin
          state_next = DONE;
        end
      end
      DONE:     state_next = IDLE;
      ERR_DONE: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbd_adr_o <= '0;
      wbd_we_o  <= 1'b0;
      wbd_sel_o <= '0;
      wbd_bl_o  <= '0;
      beat_cnt  <= '0;
      wdog      <= '0;
      err_q     <= 1'b0;
    end else if (cmd_accept) begin
      wbd_adr_o <= ycr1_wbm_align_addr(cmd_addr);
      wbd_we_o  <= cmd_we;
      wbd_sel_o <= cmd_sel;
      wbd_bl_o  <= cmd_len;
      beat_cnt  <= cmd_len;
      wdog      <= '0;
      err_q     <= 1'b0;
    end else if (state == BURST) begin
      if (beat) begin
        beat_cnt <= beat_cnt - BL_W'(1);
      end
      if (wbd_ack_i) begin
        wdog <= '0;
      end else if (wdog != TMO_MAX) begin
        wdog <= wdog + TMO_W'(1);
      end
      if (burst_end) begin
        err_q <= burst_fail;
      end
    end
  end

  ycr1_wbm_fifo2 #(.W(32)) u_wr_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (wr_flush),
    .push      (wr_push),
    .push_data (wr_data),
    .pop       (wr_pop),
    .head      (wbd_dat_o),
    .full      (wr_full),
    .empty     (wr_empty),
    .cnt       (wr_cnt)
  );

  ycr1_wbm_fifo2 #(.W(33)) u_rd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (1'b0),
    .push      (rd_push),
    .push_data ({(beat_cnt == BL_W'(1)), wbd_dat_i}),
    .pop       (rd_pop),
    .head      (rd_head),
    .full      (rd_full),
    .empty     (rd_empty),
    .cnt       (rd_cnt)
  );

endmodule

// File: tb/tb_ycr1_wb_burst_master.sv
// Randomised self-checking bench for ycr1_wb_burst_master; responder and stream models live here.
module tb_ycr1_wb_burst_master;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_we;
  logic [9:0]  cmd_len;
  logic [3:0]  cmd_sel;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        wbd_stb_o;
  logic [31:0] wbd_adr_o;
  logic        wbd_we_o;
  logic [31:0] wbd_dat_o;
  logic [3:0]  wbd_sel_o;
  logic [9:0]  wbd_bl_o;
  logic        wbd_bry_o;
  logic [31:0] wbd_dat_i;
  logic        wbd_ack_i;
  logic        wbd_lack_i;
  logic        wbd_err_i;
  logic        done;
  logic        err;

  int checks = 0;
  int passes = 0;

  ycr1_wb_burst_master #(.BL_W(10), .TMO_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_we     (cmd_we),
    .cmd_len    (cmd_len),
    .cmd_sel    (cmd_sel),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_last    (rd_last),
    .wbd_stb_o  (wbd_stb_o),
    .wbd_adr_o  (wbd_adr_o),
    .wbd_we_o   (wbd_we_o),
    .wbd_dat_o  (wbd_dat_o),
    .wbd_sel_o  (wbd_sel_o),
    .wbd_bl_o   (wbd_bl_o),
    .wbd_bry_o  (wbd_bry_o),
    .wbd_dat_i  (wbd_dat_i),
    .wbd_ack_i  (wbd_ack_i),
    .wbd_lack_i (wbd_lack_i),
    .wbd_err_i  (wbd_err_i),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic issue_cmd(input logic [31:0] addr, input logic we, input logic [9:0] len,
                           input logic [3:0] sel);
    @(negedge clk);
    wr_valid  = 1'b0;
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_we    = we;
    cmd_len   = len;
    cmd_sel   = sel;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Write burst: bounded stream producer plus a responder whose ack pattern depends on mode
  // (0 always, 1 fixed 0x5555_5555 pattern, 2 random, 3 never).
  task automatic drive_write(input logic [31:0] addr, input int len, input int mode,
                             input logic [31:0] base, output int beats, output int stb_cycles,
                             output logic done_seen, output logic err_seen,
                             output logic stb_at_done, output int leftover);
    logic [31:0] model_q[$];
    logic [31:0] pending;
    logic [31:0] expv;
    logic [31:0] pat;
    logic        ack_bit;
    int          sent;
    pat = 32'h5555_5555;
    beats = 0; stb_cycles = 0; sent = 0;
    done_seen = 1'b0; err_seen = 1'b0; stb_at_done = 1'b1;
    pending = (base == 32'd0) ? $urandom : base;
    for (int i = 0; i < 2 && sent < len; i++) begin
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = pending;
      if (wr_ready) begin
        model_q.push_back(pending);
        sent++;
        pending = (base == 32'd0) ? $urandom : base + 32'(sent);
      end
    end
    issue_cmd(addr, 1'b1, 10'(len), 4'hF);
    checks++;
    if ({wbd_stb_o, wbd_we_o, wbd_adr_o, wbd_bl_o} !== {1'b1, 1'b1, addr & 32'hFFFF_FFFC, 10'(len)}) begin
      $display("[TB] FAIL wr_cmd_latch: got stb=%0b we=%0b adr=%08h bl=%0d expected stb=1 we=1 adr=%08h bl=%0d",
               wbd_stb_o, wbd_we_o, wbd_adr_o, wbd_bl_o, addr & 32'hFFFF_FFFC, len);
    end else passes++;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (done) begin
        done_seen   = 1'b1;
        err_seen    = err;
        stb_at_done = wbd_stb_o;
        break;
      end
      if (wbd_stb_o) stb_cycles++;
      case (mode)
        0:       ack_bit = 1'b1;
        1:       ack_bit = pat[cyc % 32];
        2:       ack_bit = ($urandom_range(0, 3) != 0);
        default: ack_bit = 1'b0;
      endcase
      if (wbd_stb_o && wbd_bry_o && ack_bit) begin
        wbd_ack_i = 1'b1;
        beats++;
        checks++;
        if (model_q.size() == 0) begin
          $display("[TB] FAIL wr_beat_data: got %08h expected no beat (nothing queued)", wbd_dat_o);
        end else begin
          expv = model_q.pop_front();
          if (wbd_dat_o !== expv) begin
            $display("[TB] FAIL wr_beat_data: got %08h expected %08h", wbd_dat_o, expv);
          end else passes++;
        end
      end else begin
        wbd_ack_i = 1'b0;
      end
      if (sent < len) begin
        wr_valid = 1'b1;
        wr_data  = pending;
        if (wr_ready) begin
          model_q.push_back(pending);
          sent++;
          pending = (base == 32'd0) ? $urandom : base + 32'(sent);
        end
      end else begin
        wr_valid = 1'b0;
      end
      @(negedge clk);
    end
    wbd_ack_i = 1'b0;
    wr_valid  = 1'b0;
    leftover  = model_q.size();
  endtask

  // Read burst: responder acks whenever bry is up; consumer stalls for `hold` cycles after beat 1.
  task automatic drive_read(input logic [31:0] addr, input int len, input int hold,
                            output int beats, output logic done_seen, output logic err_seen,
                            output int leftover);
    logic [32:0] model_q[$];
    logic [32:0] expv;
    logic [31:0] d;
    logic        hold_now;
    int          held;
    beats = 0; held = 0; done_seen = 1'b0; err_seen = 1'b0;
    issue_cmd(addr, 1'b0, 10'(len), 4'hF);
    for (int cyc = 0; cyc < 300; cyc++) begin
      hold_now = (beats >= 1) && (held < hold);
      if (hold_now) held++;
      rd_ready = !hold_now;
      #1;
      if (done && !done_seen) begin
        done_seen = 1'b1;
        err_seen  = err;
      end
      if (rd_valid && rd_ready) begin
        checks++;
        if (model_q.size() == 0) begin
          $display("[TB] FAIL rd_stream: got %09h expected no entry", {rd_last, rd_data});
        end else begin
          expv = model_q.pop_front();
          if ({rd_last, rd_data} !== expv) begin
            $display("[TB] FAIL rd_stream: got last=%0b data=%08h expected last=%0b data=%08h",
                     rd_last, rd_data, expv[32], expv[31:0]);
          end else passes++;
        end
      end
      if (hold_now && wbd_stb_o && model_q.size() != 0) begin
        checks++;
        if (wbd_bry_o !== 1'b0) begin
          $display("[TB] FAIL rd_bry_backpressure: got bry=%0b expected 0 (buffered=%0d)",
                   wbd_bry_o, model_q.size());
        end else passes++;
      end
      if (wbd_stb_o && wbd_bry_o) begin
        wbd_ack_i = 1'b1;
        d = $urandom;
        wbd_dat_i = d;
        model_q.push_back({(beats == len - 1), d});
        beats++;
      end else begin
        wbd_ack_i = 1'b0;
      end
      if (done_seen && model_q.size() == 0 && !wbd_ack_i) break;
      @(negedge clk);
    end
    wbd_ack_i = 1'b0;
    leftover  = model_q.size();
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({wbd_stb_o, wbd_we_o, wbd_bry_o, done, err, rd_valid, rd_last, cmd_ready, wr_ready} !== 9'b0000_0001_1) begin
      $display("[TB] FAIL reset_ctrl: got %09b expected 000000011",
               {wbd_stb_o, wbd_we_o, wbd_bry_o, done, err, rd_valid, rd_last, cmd_ready, wr_ready});
    end else passes++;
    checks++;
    if ({wbd_adr_o, wbd_dat_o, wbd_sel_o, wbd_bl_o} !== 78'd0) begin
      $display("[TB] FAIL reset_bus: got adr=%08h dat=%08h sel=%0h bl=%0d expected all 0",
               wbd_adr_o, wbd_dat_o, wbd_sel_o, wbd_bl_o);
    end else passes++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_basic();
    int beats, stb_cycles, leftover;
    logic dn, er, sd;
    drive_write(32'h0000_1003, 4, 0, 32'h0000_00A0, beats, stb_cycles, dn, er, sd, leftover);
    checks++;
    if ({beats, leftover} !== {32'd4, 32'd0}) begin
      $display("[TB] FAIL wr_basic_beats: got beats=%0d left=%0d expected 4 and 0", beats, leftover);
    end else passes++;
    checks++;
    if ({dn, er, sd} !== 3'b100) begin
      $display("[TB] FAIL wr_basic_done: got done=%0b err=%0b stb=%0b expected 1 0 0", dn, er, sd);
    end else passes++;
  endtask

  task automatic test_read_backpressure();
    int beats, leftover;
    logic dn, er;
    drive_read(32'h0000_3000, 3, 5, beats, dn, er, leftover);
    checks++;
    if ({beats, leftover, dn, er} !== {32'd3, 32'd0, 2'b10}) begin
      $display("[TB] FAIL rd_bp_result: got beats=%0d left=%0d done=%0b err=%0b expected 3 0 1 0",
               beats, leftover, dn, er);
    end else passes++;
  endtask

  task automatic test_write_stall();
    int beats, stb_cycles, leftover;
    logic dn, er, sd;
    drive_write(32'h0000_8000, 16, 1, 32'd0, beats, stb_cycles, dn, er, sd, leftover);
    checks++;
    if ({beats, leftover, dn, er} !== {32'd16, 32'd0, 2'b10}) begin
      $display("[TB] FAIL wr_stall_result: got beats=%0d left=%0d done=%0b err=%0b expected 16 0 1 0",
               beats, leftover, dn, er);
    end else passes++;
  endtask

  task automatic test_random_bursts();
    int beats, stb_cycles, leftover, len;
    logic dn, er, sd;
    for (int n = 0; n < 3; n++) begin
      len = $urandom_range(5, 12);
      drive_write($urandom, len, 2, 32'd0, beats, stb_cycles, dn, er, sd, leftover);
      checks++;
      if ({beats, leftover, dn, er} !== {len, 32'd0, 2'b10}) begin
        $display("[TB] FAIL wr_rand_result: got beats=%0d left=%0d done=%0b err=%0b expected %0d 0 1 0",
                 beats, leftover, dn, er, len);
      end else passes++;
      len = $urandom_range(1, 8);
      drive_read($urandom, len, $urandom_range(0, 4), beats, dn, er, leftover);
      checks++;
      if ({beats, leftover, dn, er} !== {len, 32'd0, 2'b10}) begin
        $display("[TB] FAIL rd_rand_result: got beats=%0d left=%0d done=%0b err=%0b expected %0d 0 1 0",
                 beats, leftover, dn, er, len);
      end else passes++;
    end
  endtask

  task automatic test_zero_len();
    issue_cmd(32'h0000_0040, 1'b1, 10'd0, 4'hF);
    checks++;
    if ({wbd_stb_o, done, err} !== 3'b011) begin
      $display("[TB] FAIL zero_len_done: got stb=%0b done=%0b err=%0b expected 0 1 1", wbd_stb_o, done, err);
    end else passes++;
    @(negedge clk);
    checks++;
    if ({wbd_stb_o, done, err, cmd_ready} !== 4'b0001) begin
      $display("[TB] FAIL zero_len_idle: got stb=%0b done=%0b err=%0b rdy=%0b expected 0 0 0 1",
               wbd_stb_o, done, err, cmd_ready);
    end else passes++;
  endtask

  task automatic test_timeout();
    int beats, stb_cycles, leftover;
    logic dn, er, sd;
    drive_write(32'h0000_2000, 4, 3, 32'd0, beats, stb_cycles, dn, er, sd, leftover);
    checks++;
    if ({stb_cycles, beats, dn, er} !== {32'd15, 32'd0, 2'b11}) begin
      $display("[TB] FAIL timeout_abort: got stb_cycles=%0d beats=%0d done=%0b err=%0b expected 15 0 1 1",
               stb_cycles, beats, dn, er);
    end else passes++;
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b1) begin
      $display("[TB] FAIL timeout_flush: got wr_ready=%0b expected 1", wr_ready);
    end else passes++;
    drive_write(32'h0000_2000, 1, 0, 32'hC0DE_0001, beats, stb_cycles, dn, er, sd, leftover);
    checks++;
    if ({beats, dn, er} !== {32'd1, 2'b10}) begin
      $display("[TB] FAIL timeout_followup: got beats=%0d done=%0b err=%0b expected 1 1 0", beats, dn, er);
    end else passes++;
  endtask

  task automatic test_lack_abort();
    logic [31:0] d1, d2;
    d1 = $urandom;
    d2 = $urandom;
    rd_ready = 1'b0;
    issue_cmd(32'h0000_5000, 1'b0, 10'd4, 4'h3);
    checks++;
    if ({wbd_stb_o, wbd_sel_o} !== {1'b1, 4'h3}) begin
      $display("[TB] FAIL lack_start: got stb=%0b sel=%0h expected 1 3", wbd_stb_o, wbd_sel_o);
    end else passes++;
    wbd_ack_i = 1'b1;
    wbd_dat_i = d1;
    @(negedge clk);
    wbd_lack_i = 1'b1;
    wbd_dat_i  = d2;
    @(negedge clk);
    wbd_ack_i  = 1'b0;
    wbd_lack_i = 1'b0;
    checks++;
    if ({wbd_stb_o, done, err} !== 3'b011) begin
      $display("[TB] FAIL lack_end: got stb=%0b done=%0b err=%0b expected 0 1 1", wbd_stb_o, done, err);
    end else passes++;
    checks++;
    if ({rd_valid, rd_last, rd_data} !== {2'b10, d1}) begin
      $display("[TB] FAIL lack_rd0: got v=%0b last=%0b data=%08h expected 1 0 %08h", rd_valid, rd_last, rd_data, d1);
    end else passes++;
    rd_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({rd_valid, rd_last, rd_data} !== {2'b10, d2}) begin
      $display("[TB] FAIL lack_rd1: got v=%0b last=%0b data=%08h expected 1 0 %08h", rd_valid, rd_last, rd_data, d2);
    end else passes++;
    @(negedge clk);
    rd_ready = 1'b0;
    checks++;
    if (rd_valid !== 1'b0) begin
      $display("[TB] FAIL lack_rd_empty: got rd_valid=%0b expected 0", rd_valid);
    end else passes++;
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = 32'h1111_0000 + 32'(i);
    end
    issue_cmd(32'h0000_9000, 1'b1, 10'd8, 4'hF);
    checks++;
    if ({wbd_stb_o, wbd_bry_o} !== 2'b11) begin
      $display("[TB] FAIL midrst_active: got stb=%0b bry=%0b expected 1 1", wbd_stb_o, wbd_bry_o);
    end else passes++;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wbd_stb_o, wbd_we_o, wbd_bry_o, done, err, rd_valid, rd_last, cmd_ready, wr_ready} !== 9'b0000_0001_1) begin
      $display("[TB] FAIL midrst_ctrl: got %09b expected 000000011",
               {wbd_stb_o, wbd_we_o, wbd_bry_o, done, err, rd_valid, rd_last, cmd_ready, wr_ready});
    end else passes++;
    checks++;
    if ({wbd_adr_o, wbd_dat_o, wbd_sel_o, wbd_bl_o} !== 78'd0) begin
      $display("[TB] FAIL midrst_bus: got adr=%08h dat=%08h sel=%0h bl=%0d expected all 0",
               wbd_adr_o, wbd_dat_o, wbd_sel_o, wbd_bl_o);
    end else passes++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_addr   = '0;
    cmd_we     = 1'b0;
    cmd_len    = '0;
    cmd_sel    = '0;
    wr_valid   = 1'b0;
    wr_data    = '0;
    rd_ready   = 1'b0;
    wbd_dat_i  = '0;
    wbd_ack_i  = 1'b0;
    wbd_lack_i = 1'b0;
    wbd_err_i  = 1'b0;
    test_reset();
    test_write_basic();
    test_read_backpressure();
    test_write_stall();
    test_random_bursts();
    test_zero_len();
    test_timeout();
    test_lack_abort();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ycr1_wb_burst_master.md
Name: ycr1_wb_burst_master

Overview:
- Wishbone burst initiator: turns a single command (address, length, direction, byte-select) into one burst on the team's extended Wishbone bus (stb/adr/we/dat/sel/bl/bry with ack/lack/err).
- Write data comes from a valid/ready stream; read data goes out on a valid/ready stream.
- Sits between DMA/test engines and burst-capable memory responders.
- Provides 2-entry buffering per direction, an ack watchdog, and error termination.

Parameters:
- BL_W, 10, burst-length width; max burst is 2**BL_W-1 beats.
- TMO_W, 10, watchdog counter width; a burst aborts after 2**TMO_W-1 consecutive stb cycles without ack.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, reset: asynchronous, active-low.
- cmd_valid, input, 1, command request.
- cmd_ready, output, 1, high only in IDLE.
- cmd_addr, input, 32, byte address; bits [1:0] ignored.
- cmd_we, input, 1, 1 = write burst.
- cmd_len, input, BL_W, beat count.
- cmd_sel, input, 4, byte enables, constant for the whole burst.
- wr_valid / wr_ready / wr_data, in / out / in, 1 / 1 / 32, write data stream.
- rd_valid / rd_ready / rd_data / rd_last, out / in / out / out, 1 / 1 / 32 / 1, read data stream.
- wbd_stb_o, output, 1, burst strobe.
- wbd_adr_o, output, 32, start address.
- wbd_we_o, output, 1, write enable.
- wbd_dat_o, output, 32, write data.
- wbd_sel_o, output, 4, byte select.
- wbd_bl_o, output, BL_W, burst length.
- wbd_bry_o, output, 1, master ready for next beat.
- wbd_dat_i, input, 32, read data.
- wbd_ack_i, wbd_lack_i, wbd_err_i, input, 1 each, beat ack, last-beat ack, error.
- done, output, 1, one-cycle pulse at burst end.
- err, output, 1, one-cycle pulse, valid with done.

Behaviour:
- Reset values: stb/we/bry/done/err/rd_valid/rd_last = 0; cmd_ready = 1; adr/dat/sel/bl = 0; state IDLE; both buffers empty; beat and watchdog counters 0.
- States:
  - IDLE: cmd_valid & cmd_len!=0 -> BURST.
  - IDLE: cmd_valid & cmd_len==0 -> ERR_DONE. No bus activity.
  - BURST: burst-end condition -> DONE.
  - DONE / ERR_DONE -> IDLE after 1 cycle.
- Command latch, on acceptance in IDLE:
  - adr_o = {cmd_addr[31:2],2'b00}; we_o, sel_o, bl_o = cmd values.
  - Beat counter = cmd_len.
  - stb_o rises on the next cycle and stays high through BURST.
  - adr/we/sel/bl hold constant until stb_o falls.
- Beat transfer: any posedge where stb_o & wbd_ack_i are sampled high. Each beat decrements the beat counter.
- Burst end (first match wins):
  - wbd_err_i sampled high -> err.
  - Watchdog expiry -> err.
  - Beat with counter==1 -> normal end.
  - lack_i sampled with counter!=1 -> err; this beat's data is still consumed.
- stb_o and bry_o drop on the cycle after burst end.
- Write path, 2-entry FIFO:
  - wr_ready = FIFO not full.
  - dat_o = FIFO head; bry_o = stb_o & FIFO non-empty.
  - Head pops on each ack.
  - Push and pop in the same cycle when full is legal.
  - FIFO is pre-loadable in IDLE.
- Read path, 2-entry FIFO:
  - wbd_dat_i pushed on each ack.
  - bry_o = stb_o & (cnt==0 | (cnt==1 & rd_ready)). This guarantees room for one in-flight beat.
  - rd_last is marked on the entry pushed with counter==1.
  - rd_valid = FIFO non-empty.
- Ack with a full read FIFO is a protocol violation: the beat is dropped and err is raised.
- Watchdog:
  - Counts stb cycles without ack; cleared on every ack.
  - Saturates at 2**TMO_W-1, then aborts.
  - Counts even while bry_o=0.
- done: asserted in DONE and ERR_DONE; err co-asserted on failure.
- Abort: residual write-FIFO entries are flushed; the read FIFO keeps received data.
- Async reset mid-burst: stb/bry drop immediately; all state cleared.
- cmd_valid while busy is ignored, since cmd_ready=0.
- Counter arithmetic is BL_W-bit unsigned; no wrap, because 0 is rejected.

Decomposition:
- Package ycr1_wb_burst_pkg:
  - state enum type_wbm_state_e {IDLE, BURST, DONE, ERR_DONE}.
  - Constant YCR1_WBM_FIFO_DEPTH=2.
  - Function for aligned-address formation.
- Sub-module ycr1_wbm_fifo2:
  - 2-entry, parameterised-width FIFO.
  - Ports: push/pop/full/empty/cnt/flush.
  - Instantiated twice: write path, and read path with 33 bits = data + last.

Test Plan:
- Write, cmd_addr=0x1003, len=4, sel=0xF; wr stream 0xA0..0xA3 preloaded; responder acks every cycle -> adr_o=0x1000, bl_o=4, four acks consume 0xA0..0xA3 in order, done=1, err=0, stb low the next cycle.
- Read, len=3, rd_ready held 0 after the first beat -> bry_o drops; no more than 2 entries buffered; after rd_ready=1, rd_data sequence correct, rd_last on 3rd beat, done=1.
- Random ack stall pattern 0x5555_5555, len=16 write -> exactly 16 beats, data order preserved, no duplicate acceptance.
- cmd_len=0 -> stb_o never rises, done=1 & err=1 one cycle after acceptance.
- Responder never acks, TMO_W=4 -> abort after 15 stb cycles, done=1, err=1, write FIFO flushed.
- wbd_lack_i on beat 2 of len=4 read -> burst ends, err=1, rd FIFO holds 2 beats with the 2nd unmarked as last; rst_n pulsed mid-burst -> all outputs return to reset values immediately.
